// File: rtl/spi_slave_pkg.sv
// Shared types and default sizes for the spi_slave SPI target.
package spi_slave_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer for an asynchronous pin with registered rise/fall strobes.
module spi_sync
  import spi_slave_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;

  // Synchronizer chain: left unreset so the pin level is tracked through reset
  always_ff @(posedge clk) begin
    r_sync <= {r_sync[STAGES-2:0], i_d};
    r_prev <= r_sync[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= r_sync[STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[STAGES-1] & r_prev;
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 target, oversampled on clk; returns a preloaded word on MISO.
// Optional pending/overrun tracking enabled by defining SPI_SLAVE_OVERRUN_EN.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_scl,
  input  logic                  spi_cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  valid,
  output logic                  busy,
  input  logic                  rx_ack,
  output logic                  overrun
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic w_scl_rise, w_scl_fall, w_scl_s_unused;
  logic w_cs_s, w_cs_rise_unused, w_cs_fall_unused;
  logic w_mosi_s;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  state_t r_state, w_state_nxt;
  logic   w_start, w_stop;

  logic                  r_armed;
  logic                  r_miso;
  logic                  r_valid;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_tx_buf, r_tx_sh, r_rx_sh, r_rx_data;
  logic [DATA_WIDTH-1:0] w_rx_next;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_scl (
    .clk(clk), .reset(reset), .i_d(spi_scl),
    .o_q(w_scl_s_unused), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .reset(reset), .i_d(spi_cs),
    .o_q(w_cs_s), .o_rise(w_cs_rise_unused), .o_fall(w_cs_fall_unused)
  );

  always_ff @(posedge clk) begin
    r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_rx_next = {r_rx_sh[DATA_WIDTH-2:0], w_mosi_s};

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Entry needs a CS-high sighting since reset, so a reset mid-frame drops the frame
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_stop      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_cs_s && r_armed) begin
          w_state_nxt = ACTIVE;
          w_start     = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_cs_s) begin
          w_state_nxt = IDLE;
          w_stop      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_armed   <= 1'b0;
      r_miso    <= 1'b0;
      r_valid   <= 1'b0;
      r_cnt     <= '0;
      r_tx_buf  <= '0;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
    end else begin
      r_valid <= 1'b0;
      r_armed <= r_armed | w_cs_s;
      if (tx_load) r_tx_buf <= tx_data;
      if (w_start) begin
        r_tx_sh <= r_tx_buf;
        r_miso  <= r_tx_buf[DATA_WIDTH-1];
        r_cnt   <= '0;
      end else if (w_stop) begin
        r_miso <= 1'b0;
        r_cnt  <= '0;
      end else if (r_state == ACTIVE) begin
        if (w_scl_rise) begin
          r_rx_sh <= w_rx_next;
          if (r_cnt == CW'(DATA_WIDTH - 1)) begin
            r_rx_data <= w_rx_next;
            r_valid   <= 1'b1;
            r_cnt     <= '0;
            r_tx_sh   <= r_tx_buf;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end else if (w_scl_fall) begin
          // Counter at 0 here means a word just completed: present the reloaded MSB unshifted
          if (r_cnt == '0) begin
            r_miso <= r_tx_sh[DATA_WIDTH-1];
          end else begin
            r_tx_sh <= r_tx_sh << 1;
            r_miso  <= r_tx_sh[DATA_WIDTH-2];
          end
        end
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic r_pending, r_overrun;

  // A same-cycle ack consumes the previous word, so the new one is not an overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_valid) begin
      if (r_pending && !rx_ack) r_overrun <= 1'b1;
      r_pending <= 1'b1;
    end else if (rx_ack) begin
      r_pending <= 1'b0;
    end
  end

  assign overrun = r_overrun;
`else
  logic w_rx_ack_unused;
  assign w_rx_ack_unused = rx_ack;
  assign overrun         = 1'b0;
`endif

  assign miso    = r_miso;
  assign rx_data = r_rx_data;
  assign valid   = r_valid;
  assign busy    = (r_state == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: SPI mode-0 initiator model at f_clk/8, valid-driven monitor.
module tb_spi_slave;

  localparam int HALF = 4;
`ifdef SPI_SLAVE_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, spi_scl, spi_cs, mosi, miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_load, valid, busy, rx_ack, overrun;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       prev_v = 1'b0;

  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_scl(spi_scl), .spi_cs(spi_cs), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
    .valid(valid), .busy(busy), .rx_ack(rx_ack), .overrun(overrun)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Monitor: every valid pulse pops one expected word
  always @(negedge clk) begin
    if (!reset && valid) begin
      checks++;
      if (prev_v) begin
        errors++;
        $display("FAIL valid_width: got 2+ cycles expected 1");
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got rx_data 0x%0h expected no valid", rx_data);
      end else begin
        check("rx_word", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_v = valid;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] v);
    tx_data = v; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] d, input int nbits, input bit ld,
                           input logic [7:0] ldv, output logic [7:0] m);
    m = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = d[7-i];
      if (ld && i == 3) begin
        load_tx(ldv);
        wait_clk(HALF - 1);
      end else begin
        wait_clk(HALF);
      end
      spi_scl = 1'b1;
      m = {m[6:0], miso};
      wait_clk(HALF);
      spi_scl = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic [7:0] exp_m, input string nm);
    logic [7:0] m;
    exp_q.push_back(d);
    spi_cs = 1'b0;
    wait_clk(4);
    check({nm, "_busy"}, {31'd0, busy}, 32'd1);
    send_bits(d, 8, 1'b0, 8'h00, m);
    check({nm, "_miso_word"}, {24'd0, m}, {24'd0, exp_m});
    wait_clk(4);
    spi_cs = 1'b1;
    wait_clk(6);
    check({nm, "_miso_idle"}, {31'd0, miso}, 32'd0);
    check({nm, "_rx_data"}, {24'd0, rx_data}, {24'd0, d});
  endtask

  initial begin
    logic [7:0] m1, m2;
    reset = 1'b1; spi_scl = 1'b0; spi_cs = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_load = 1'b0; rx_ack = 1'b0;

    // Reset with CS high and SCL toggling
    wait_clk(5);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      spi_scl = 1'b1; wait_clk(HALF);
      spi_scl = 1'b0; wait_clk(HALF);
    end
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);

    // Single frame: receive 0x3C, return 0xA5
    load_tx(8'hA5);
    wait_clk(2);
    frame(8'h3C, 8'hA5, "t2");

    // Two words in one CS window, new TX value loaded during the first word
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    spi_cs = 1'b0;
    wait_clk(4);
    send_bits(8'h12, 8, 1'b1, 8'h5A, m1);
    send_bits(8'h34, 8, 1'b0, 8'h00, m2);
    wait_clk(4);
    spi_cs = 1'b1;
    wait_clk(6);
    check("t3_miso_w1", {24'd0, m1}, 32'hA5);
    check("t3_miso_w2", {24'd0, m2}, 32'h5A);
    check("t3_rx_data", {24'd0, rx_data}, 32'h34);

    // CS raised after 5 bits: partial word discarded
    spi_cs = 1'b0;
    wait_clk(4);
    send_bits(8'h96, 5, 1'b0, 8'h00, m1);
    wait_clk(4);
    spi_cs = 1'b1;
    wait_clk(8);
    check("t4_rx_kept", {24'd0, rx_data}, 32'h34);
    check("t4_busy", {31'd0, busy}, 32'd0);
    frame(8'hFF, 8'h5A, "t4");

    // Reset at bit 4 with CS held low: frame dropped until CS cycles
    spi_cs = 1'b0;
    wait_clk(4);
    send_bits(8'h99, 4, 1'b0, 8'h00, m1);
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    send_bits(8'h99, 4, 1'b0, 8'h00, m1);
    wait_clk(6);
    check("t5_rx_cleared", {24'd0, rx_data}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_miso", {31'd0, miso}, 32'd0);
    spi_cs = 1'b1;
    wait_clk(6);
    frame(8'h66, 8'h00, "t5");

    // Pending/overrun: acknowledged words, then two unacknowledged words
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);
    load_tx(8'hC3);
    frame(8'h11, 8'hC3, "t6a");
    pulse_ack();
    frame(8'h22, 8'hC3, "t6b");
    pulse_ack();
    check("t6_no_overrun", {31'd0, overrun}, 32'd0);
    frame(8'h33, 8'hC3, "t6c");
    check("t6_one_pending", {31'd0, overrun}, 32'd0);
    frame(8'h44, 8'hC3, "t6d");
    check("t6_overrun", {31'd0, overrun}, {31'd0, OVR_EN});

    wait_clk(4);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
